// File: rtl/shift_pin_nib_out.sv
// Parallel-in / nibble-out transmitter: a byte goes into a one-entry holding register
// and is then presented MSB-nibble-first on dout, one nibble per qualified shift strobe.
module shift_pin_nib_out #(
   parameter int NIB_W   = 4,
   parameter int NUM_NIB = 2,
   localparam int W      = NIB_W * NUM_NIB
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           select,
   input  logic           load,
   input  logic [0:W-1]   din,
   input  logic           shift,
   input  logic           clr_err,
   output logic [0:NIB_W-1] dout,
   output logic           dout_oe,
   output logic           hold_full,
   output logic           busy,
   output logic           done,
   output logic           overrun,
   output logic           underrun
);

   localparam int CNT_W = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NIB - 1);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t             state_r, state_s;
   logic [0:W-1]       hold_r, hold_s;
   logic [0:W-1]       sr_r, sr_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic               hold_full_r, hold_full_s;
   logic               done_r, done_s;
   logic               overrun_r, overrun_s;
   logic               underrun_r, underrun_s;
   logic               oe_r;
   logic [0:NIB_W-1]   dout_r, dout_s;
   logic               take_s;
   logic               ovr_set_s;
   logic               unr_set_s;

   // Next-state logic: holding-register transfer, nibble shifting and flag updates
   always_comb begin
      state_s     = state_r;
      hold_s      = hold_r;
      sr_s        = sr_r;
      cnt_s       = cnt_r;
      hold_full_s = hold_full_r;
      done_s      = 1'b0;
      take_s      = 1'b0;
      ovr_set_s   = 1'b0;
      unr_set_s   = 1'b0;
      if (select) begin
         case (state_r)
            IDLE: begin
               if (shift) begin
                  unr_set_s = 1'b1;
               end else begin
                  unr_set_s = 1'b0;
               end
               if (hold_full_r) begin
                  take_s = 1'b1;
               end else begin
                  take_s = 1'b0;
               end
            end
            ACTIVE: begin
               if (shift) begin
                  sr_s  = {sr_r[NIB_W:W-1], {NIB_W{1'b0}}};
                  cnt_s = cnt_r + CNT_W'(1);
                  if (cnt_r == LAST_CNT) begin
                     done_s = 1'b1;
                     if (hold_full_r) begin
                        take_s = 1'b1;
                     end else begin
                        state_s = IDLE;
                     end
                  end else begin
                     done_s = 1'b0;
                  end
               end else begin
                  state_s = state_r;
               end
            end
            default: begin
               state_s = IDLE;
            end
         endcase
         // A transfer empties hold; a same-cycle load refills it and is then not an overrun
         if (take_s) begin
            sr_s        = hold_r;
            cnt_s       = {CNT_W{1'b0}};
            state_s     = ACTIVE;
            hold_full_s = 1'b0;
         end else begin
            hold_full_s = hold_full_r;
         end
         if (load) begin
            hold_s      = din;
            hold_full_s = 1'b1;
            ovr_set_s   = hold_full_r & ~take_s;
         end else begin
            hold_s = hold_r;
         end
      end else begin
         state_s = state_r;
      end
      overrun_s  = ovr_set_s | (overrun_r & ~clr_err);
      underrun_s = unr_set_s | (underrun_r & ~clr_err);
      if (state_s == ACTIVE) begin
         dout_s = sr_s[0:NIB_W-1];
      end else begin
         dout_s = {NIB_W{1'b0}};
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         hold_r      <= {W{1'b0}};
         sr_r        <= {W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         hold_full_r <= 1'b0;
         done_r      <= 1'b0;
         overrun_r   <= 1'b0;
         underrun_r  <= 1'b0;
         oe_r        <= 1'b0;
         dout_r      <= {NIB_W{1'b0}};
      end else begin
         state_r     <= state_s;
         hold_r      <= hold_s;
         sr_r        <= sr_s;
         cnt_r       <= cnt_s;
         hold_full_r <= hold_full_s;
         done_r      <= done_s;
         overrun_r   <= overrun_s;
         underrun_r  <= underrun_s;
         oe_r        <= select;
         dout_r      <= dout_s;
      end
   end

   assign dout      = dout_r;
   assign dout_oe   = oe_r;
   assign hold_full = hold_full_r;
   assign busy      = (state_r == ACTIVE);
   assign done      = done_r;
   assign overrun   = overrun_r;
   assign underrun  = underrun_r;

endmodule

// File: tb/tb_shift_pin_nib_out.sv
// Bench for shift_pin_nib_out: directed scenarios plus random traffic, all checked
// against a nibble-queue model of the transmitter.
module tb_shift_pin_nib_out;

   logic       clk;
   logic       rst_n;
   logic       select;
   logic       load;
   logic [0:7] din;
   logic       shift;
   logic       clr_err;
   logic [0:3] dout;
   logic       dout_oe;
   logic       hold_full;
   logic       busy;
   logic       done;
   logic       overrun;
   logic       underrun;

   int n_chk  = 0;
   int n_fail = 0;

   // model: words waiting to leave are a queue of nibbles, the front one is on dout
   logic [3:0] m_q[$];
   logic [7:0] m_hold;
   bit         m_hv, m_done, m_ovr, m_unr, m_oe;
   logic [7:0] rx;

   shift_pin_nib_out #(.NIB_W(4), .NUM_NIB(2)) dut (
      .clk(clk), .rst_n(rst_n), .select(select), .load(load), .din(din),
      .shift(shift), .clr_err(clr_err), .dout(dout), .dout_oe(dout_oe),
      .hold_full(hold_full), .busy(busy), .done(done), .overrun(overrun),
      .underrun(underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_hold = 8'h00;
      m_hv   = 1'b0;
      m_done = 1'b0;
      m_ovr  = 1'b0;
      m_unr  = 1'b0;
      m_oe   = 1'b0;
   endtask

   task automatic model_step();
      bit take, o_set, u_set;
      take  = 1'b0;
      o_set = 1'b0;
      u_set = 1'b0;
      m_done = 1'b0;
      if (select) begin
         if (m_q.size() == 0) begin
            if (shift) u_set = 1'b1;
            if (m_hv) take = 1'b1;
         end else if (shift) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
               m_done = 1'b1;
               if (m_hv) take = 1'b1;
            end
         end
         if (take) begin
            m_q.push_back(4'((m_hold >> 4) & 8'h0F));
            m_q.push_back(4'(m_hold & 8'h0F));
         end
         if (load && m_hv && !take) o_set = 1'b1;
         if (load) begin
            m_hold = din;
            m_hv   = 1'b1;
         end else if (take) begin
            m_hv = 1'b0;
         end
      end
      m_ovr = o_set || (m_ovr && !clr_err);
      m_unr = u_set || (m_unr && !clr_err);
      m_oe  = select;
   endtask

   task automatic check_all();
      chk("dout",      32'(dout),      32'((m_q.size() != 0) ? m_q[0] : 4'h0));
      chk("busy",      32'(busy),      32'(m_q.size() != 0));
      chk("hold_full", 32'(hold_full), 32'(m_hv));
      chk("done",      32'(done),      32'(m_done));
      chk("overrun",   32'(overrun),   32'(m_ovr));
      chk("underrun",  32'(underrun),  32'(m_unr));
      chk("dout_oe",   32'(dout_oe),   32'(m_oe));
   endtask

   // one clock: model sees the inputs at the edge, outputs are compared at the falling edge
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input bit ld, input logic [7:0] d, input bit sh, input bit clr);
      load    = ld;
      din     = d;
      shift   = sh;
      clr_err = clr;
   endtask

   initial begin
      rst_n = 1'b0; select = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      select = 1'b1;
      cyc();

      // reset in the middle of a word
      drive(1'b1, 8'hA3, 1'b0, 1'b0); cyc();
      drive(1'b0, 8'h00, 1'b0, 1'b0); cyc();
      drive(1'b0, 8'h00, 1'b1, 1'b0); cyc();
      chk("mid_dout", 32'(dout), 32'h3);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_hold_full", 32'(hold_full), 32'h0);
      chk("rst_oe", 32'(dout_oe), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_busy", 32'(busy), 32'h0);

      // basic word, two-edge latency
      drive(1'b1, 8'hF5, 1'b0, 1'b0); cyc();
      chk("lat_hold_full", 32'(hold_full), 32'h1);
      chk("lat_busy0", 32'(busy), 32'h0);
      drive(1'b0, 8'h00, 1'b0, 1'b0); cyc();
      chk("basic_busy", 32'(busy), 32'h1);
      chk("basic_n0", 32'(dout), 32'hF);
      drive(1'b0, 8'h00, 1'b1, 1'b0); cyc();
      chk("basic_n1", 32'(dout), 32'h5);
      cyc();
      chk("basic_done", 32'(done), 32'h1);
      chk("basic_idle", 32'(busy), 32'h0);
      chk("basic_dout0", 32'(dout), 32'h0);
      drive(1'b0, 8'h00, 1'b0, 1'b0); cyc();
      chk("basic_done_pulse", 32'(done), 32'h0);

      // back-to-back words, no gap
      drive(1'b1, 8'h12, 1'b0, 1'b0); cyc();
      drive(1'b0, 8'h00, 1'b0, 1'b0); cyc();
      chk("b2b_n0", 32'(dout), 32'h1);
      drive(1'b1, 8'h34, 1'b0, 1'b0); cyc();
      chk("b2b_hold_full", 32'(hold_full), 32'h1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0); cyc();
         chk("b2b_done", 32'(done), 32'((i == 1) || (i == 3)));
         chk("b2b_busy", 32'(busy), 32'(i != 3));
         if (i < 3) chk("b2b_dout", 32'(dout), 32'(i + 2));
      end
      chk("b2b_ovr", 32'(overrun), 32'h0);

      // overrun and clearing
      drive(1'b1, 8'h9A, 1'b0, 1'b0); cyc();
      drive(1'b1, 8'h56, 1'b0, 1'b0); cyc();
      drive(1'b1, 8'h78, 1'b0, 1'b0); cyc();
      chk("ovr_set", 32'(overrun), 32'h1);
      drive(1'b0, 8'h00, 1'b0, 1'b1); cyc();
      chk("ovr_clr", 32'(overrun), 32'h0);
      drive(1'b1, 8'h11, 1'b0, 1'b1); cyc();
      chk("ovr_set_wins", 32'(overrun), 32'h1);
      drive(1'b0, 8'h00, 1'b1, 1'b0); cyc(); cyc();
      chk("ovr_newest_hold", 32'(dout), 32'h1);
      cyc(); cyc();
      drive(1'b0, 8'h00, 1'b0, 1'b1); cyc();

      // underrun and select gating
      drive(1'b0, 8'h00, 1'b1, 1'b0); cyc();
      chk("unr_set", 32'(underrun), 32'h1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      select = 1'b0; cyc();
      chk("sel_oe", 32'(dout_oe), 32'h0);
      drive(1'b1, 8'hFF, 1'b1, 1'b0); cyc();
      chk("sel_hold_full", 32'(hold_full), 32'h0);
      chk("sel_busy", 32'(busy), 32'h0);
      select = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b1); cyc();

      // loopback through a behavioural nibble receiver
      rx = 8'h00;
      drive(1'b1, 8'hC6, 1'b0, 1'b0); cyc();
      drive(1'b0, 8'h00, 1'b0, 1'b0); cyc();
      for (int i = 0; i < 2; i++) begin
         rx = {rx[3:0], dout};
         drive(1'b0, 8'h00, 1'b1, 1'b0); cyc();
      end
      chk("loopback", 32'(rx), 32'hC6);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         select  = ($urandom_range(0, 9) != 0);
         load    = ($urandom_range(0, 3) == 0);
         din     = 8'($urandom);
         shift   = ($urandom_range(0, 2) == 0);
         clr_err = ($urandom_range(0, 7) == 0);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_pin_nib_out.md
Name: shift_pin_nib_out

Overview:
- Transmit-side counterpart of the nibble-in/parallel-out receiver. Accepts a parallel byte from the TI bus side and presents it as a sequence of 4-bit nibbles on a nibble port, most-significant nibble first.
- The Pi side consumes the sequence with qualified shift strobes.
- A one-entry holding register decouples bus writes from nibble shifting. Busy, done and sticky error flags support software handshake.
- Single clock domain; Pi strobes arrive already synchronised and edge-detected.

Parameters:
- NIB_W, 4, nibble width in bits.
- NUM_NIB, 2, nibbles per word; word width W = NIB_W*NUM_NIB.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- select  in  1  block enable; when low, load/shift ignored and state held.
- load  in  1  one-cycle pulse: capture din into holding register.
- din  in  [0:W-1]  parallel word; bit 0 is MSB.
- shift  in  1  one-cycle pulse: advance to next nibble.
- clr_err  in  1  clear sticky error flags.
- dout  out  [0:NIB_W-1]  current nibble.
- dout_oe  out  1  drive enable for external tri-state buffer; equals registered select.
- hold_full  out  1  holding register occupied.
- busy  out  1  a word is being shifted out (ACTIVE).
- done  out  1  one-cycle pulse after the last nibble of a word is shifted.
- overrun  out  1  sticky: load arrived while holding register full and not being consumed.
- underrun  out  1  sticky: shift arrived while IDLE.

Behaviour:
- Reset (rst_n low, async): all outputs 0; state IDLE; sr, hold and cnt cleared.
- Registers: hold[0:W-1], hold_full, sr[0:W-1], cnt (ceil(log2 NUM_NIB) bits, min 1), state {IDLE, ACTIVE}.
- dout = sr[0:NIB_W-1] when ACTIVE, else 0.
- dout_oe: registered copy of select, updated each cycle.
- load & select: hold <= din and hold_full <= 1.
  - If hold_full was already 1 and hold is not transferred the same cycle, overrun <= 1; the new din still overwrites hold.
- IDLE & hold_full: sr <= hold, cnt <= 0, state <= ACTIVE, hold_full <= 0.
  - A simultaneous load refills hold and keeps hold_full = 1, with no overrun.
- Latency: load sampled at edge N gives hold_full = 1 after N. At edge N+1 the word transfers, so busy = 1 and dout = din[0:NIB_W-1] after N+1.
- shift & select & ACTIVE: sr <= sr shifted left by NIB_W (zero fill), cnt <= cnt+1.
  - On the shift where cnt == NUM_NIB-1: done <= 1 for one cycle.
  - If hold_full, reload sr from hold, cnt <= 0 and stay ACTIVE (back-to-back, no gap cycle). Otherwise state <= IDLE.
- shift & select & IDLE: no state change; underrun <= 1.
- load and shift in the same cycle: both are honoured independently per the rules above.
- select low: load and shift ignored (no flag updates); sr, hold, cnt and state held; dout_oe drops one cycle later.
- clr_err: overrun and underrun <= 0, except a flag being set in the same cycle stays 1 (set wins).
- done defaults to 0 every cycle it is not asserted.
- Bit ordering is the inverse of the receiver: feeding dout nibbles in order into the receiver reproduces din.

Test Plan:
- Reset mid-word: load 8'hA3, one shift, assert rst_n=0 -> all outputs 0 immediately; after release busy=0, hold_full=0, dout=0.
- Basic word: select=1, load din=8'hF5 -> after 2 edges busy=1, dout=4'hF. Shift -> dout=4'h5. Shift -> done pulse of 1 cycle, busy=0, dout=0, no error flags.
- Back-to-back: load 8'h12, then load 8'h34 while ACTIVE -> hold_full=1. Emit 4 shifts -> dout sequence 1,2,3,4. done pulses twice; busy stays 1 with no idle cycle between words; overrun=0.
- Overrun/clear: with hold_full=1 and ACTIVE, load 8'h56 then 8'h78 -> overrun=1 and hold=8'h78. Pulse clr_err -> overrun=0. clr_err coincident with a new overrun -> overrun stays 1.
- Underrun and select gating: shift while IDLE -> underrun=1. With select=0, pulse load 8'hFF and shift -> no state change, hold_full unchanged, dout_oe=0 one cycle after select falls.
- Loopback: connect dout and shift to a nibble-in/parallel-out receiver instance, send 8'hC6 -> receiver latches 8'hC6.
